// File: rtl/serial_add_sequencer_pkg.sv
// Shared constants for the bit-serial add/subtract sequencer: FSM encoding and NZCV packing.
package serial_add_sequencer_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;
    localparam int unsigned FLAG_W = 4;

    function automatic logic [FLAG_W-1:0] pack_nzcv(input logic n, input logic z,
                                                    input logic c, input logic v);
        logic [FLAG_W-1:0] f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/serial_add_sequencer_if.sv
// Operation request / result bus between a requester and the serial add/subtract sequencer.
interface serial_add_sequencer_if #(
    parameter int unsigned WIDTH = 64
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             n;
    logic             z;
    logic             c;
    logic             v;

    modport master (output start, sub, a, b,
                    input  busy, done, result, n, z, c, v);
    modport slave  (input  start, sub, a, b,
                    output busy, done, result, n, z, c, v);
endinterface

// File: rtl/serial_add_sequencer_full_add.sv
// One-bit full adder from two NAND-only half adders plus an OR of their carries; combinational.
module nand_half_add (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    logic n1, n2, n3;

    assign n1 = ~(a & b);
    assign n2 = ~(a & n1);
    assign n3 = ~(b & n1);
    assign s  = ~(n2 & n3);
    assign c  = ~(n1 & n1);
endmodule

module serial_full_add (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic s1, c1, c2;

    nand_half_add u_ha0 (.a(a),  .b(b),  .s(s1), .c(c1));
    nand_half_add u_ha1 (.a(s1), .b(ci), .s(s),  .c(c2));

    assign co = c1 | c2;
endmodule

// File: rtl/serial_add_sequencer.sv
// Bit-serial WIDTH-bit ADD/SUB with NZCV flags, one full-adder cell time-shared LSB first.
module serial_add_sequencer
    import serial_add_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    serial_add_sequencer_if.slave bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [1:0]        state, state_nx;
    logic              load;
    logic [WIDTH-1:0]  sa, sb, result_q;
    logic              carry, zacc;
    logic [CNT_W-1:0]  cnt;
    logic              busy_q, done_q;
    logic [FLAG_W-1:0] flags_q;
    logic              s, co, last;

    serial_full_add u_fa (.a(sa[0]), .b(sb[0]), .ci(carry), .s(s), .co(co));

    assign last = (cnt == CNT_W'(WIDTH - 1));

    // Next state; IDLE, DONE and the unused encoding all accept a new request
    always_comb begin
        state_nx = ST_IDLE;
        load     = 1'b0;
        case (state)
            ST_RUN:  state_nx = last ? ST_DONE : ST_RUN;
            default: begin
                if (bus.start) begin
                    state_nx = ST_RUN;
                    load     = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // SA doubles as the partial-sum shifter; result/flags only move on the final bit
    always_ff @(posedge clk) begin
        if (reset) begin
            sa       <= '0;
            sb       <= '0;
            carry    <= 1'b0;
            zacc     <= 1'b0;
            cnt      <= '0;
            result_q <= '0;
            flags_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            busy_q <= (state == ST_RUN);
            done_q <= (state == ST_DONE);
            if (load) begin
                sa    <= bus.a;
                sb    <= bus.sub ? ~bus.b : bus.b;
                carry <= bus.sub;
                zacc  <= 1'b0;
                cnt   <= '0;
            end else if (state == ST_RUN) begin
                sa    <= {s, sa[WIDTH-1:1]};
                sb    <= {1'b0, sb[WIDTH-1:1]};
                carry <= co;
                zacc  <= zacc | s;
                cnt   <= cnt + CNT_W'(1);
                if (last) begin
                    result_q <= {s, sa[WIDTH-1:1]};
                    flags_q  <= pack_nzcv(s, ~(zacc | s), co, carry ^ co);
                end
            end
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.n      = flags_q[FLAG_N];
    assign bus.z      = flags_q[FLAG_Z];
    assign bus.c      = flags_q[FLAG_C];
    assign bus.v      = flags_q[FLAG_V];

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Randomized and directed checks of serial_add_sequencer at WIDTH 64 and 8 against an arithmetic model.
module tb_serial_add_sequencer;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    serial_add_sequencer_if #(.WIDTH(64)) b64 ();
    serial_add_sequencer_if #(.WIDTH(8))  b8  ();

    serial_add_sequencer #(.WIDTH(64)) u_dut64 (.clk(clk), .reset(reset), .bus(b64));
    serial_add_sequencer #(.WIDTH(8))  u_dut8  (.clk(clk), .reset(reset), .bus(b8));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: unsigned sum for C/result, exact signed sum for V
    task automatic model(input int w, input logic [63:0] a_in, input logic [63:0] b_in,
                         input logic sub, output logic [63:0] res, output logic [3:0] nzcv);
        logic [63:0]        mask, a, b;
        logic [64:0]        u;
        logic signed [65:0] sa_s, sb_s, r, lim;
        logic               n, z, c, v;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        a    = a_in & mask;
        b    = b_in & mask;
        u    = {1'b0, a} + (sub ? ({1'b0, ~b & mask} + 65'd1) : {1'b0, b});
        res  = u[63:0] & mask;
        c    = u[w];
        sa_s = $signed({2'b00, a});
        sb_s = $signed({2'b00, b});
        if (a[w-1]) sa_s = sa_s - (66'sd1 <<< w);
        if (b[w-1]) sb_s = sb_s - (66'sd1 <<< w);
        lim  = 66'sd1 <<< (w - 1);
        r    = sub ? (sa_s - sb_s) : (sa_s + sb_s);
        v    = (r >= lim) || (r < -lim);
        n    = res[w-1];
        z    = (res == 64'd0);
        nzcv = {n, z, c, v};
    endtask

    function automatic logic [63:0] res_of(input bit w8);
        return w8 ? 64'(b8.result) : b64.result;
    endfunction
    function automatic logic [3:0] flags_of(input bit w8);
        return w8 ? {b8.n, b8.z, b8.c, b8.v} : {b64.n, b64.z, b64.c, b64.v};
    endfunction
    function automatic logic busy_of(input bit w8);
        return w8 ? b8.busy : b64.busy;
    endfunction
    function automatic logic done_of(input bit w8);
        return w8 ? b8.done : b64.done;
    endfunction

    task automatic drive(input bit w8, input logic st, input logic [63:0] a,
                         input logic [63:0] b, input logic sub);
        if (w8) begin
            b8.start = st; b8.a = a[7:0]; b8.b = b[7:0]; b8.sub = sub;
        end else begin
            b64.start = st; b64.a = a; b64.b = b; b64.sub = sub;
        end
    endtask

    // One pulse-started operation; checks latency, busy length, done width, result and flags
    task automatic run_op(input bit w8, input logic [63:0] a, input logic [63:0] b,
                          input logic sub, input string tag);
        int          w = w8 ? 8 : 64;
        int          busy_cnt = 0, done_cyc = 0;
        logic [63:0] er, gr;
        logic [3:0]  ef, gf;
        model(w, a, b, sub, er, ef);
        drive(w8, 1'b1, a, b, sub);
        @(posedge clk); #1;
        drive(w8, 1'b0, a, b, sub);
        for (int cyc = 1; cyc < 200; cyc++) begin
            @(posedge clk); #1;
            if (busy_of(w8)) busy_cnt++;
            if (done_cyc != 0) begin
                check({tag, "_done_width"}, 64'(done_of(w8)), 64'd0);
                break;
            end
            if (done_of(w8)) begin
                done_cyc = cyc;
                gr = res_of(w8);
                gf = flags_of(w8);
            end
        end
        if (done_cyc == 0) begin
            check({tag, "_timeout"}, 64'd0, 64'd1);
        end else begin
            check({tag, "_latency"}, 64'(done_cyc), 64'(w + 1));
            check({tag, "_busy_len"}, 64'(busy_cnt), 64'(w));
            check({tag, "_result"}, gr, er);
            check({tag, "_nzcv"}, 64'(gf), 64'(ef));
        end
    endtask

    function automatic logic [63:0] rnd_operand(input int w);
        logic [63:0] x;
        case ($urandom_range(0, 5))
            0:       x = 64'd0;
            1:       x = {64{1'b1}};
            2:       x = 64'd1 << (w - 1);
            3:       x = (64'd1 << (w - 1)) - 64'd1;
            default: x = {$urandom(), $urandom()};
        endcase
        return x;
    endfunction

    initial begin
        int          busy_cnt, done_cnt, first_done, second_done, cyc0;
        bit          hold_ok;
        logic [63:0] ra, rb;
        logic        rs;

        reset = 1'b1;
        drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
        drive(1'b1, 1'b0, 64'd0, 64'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(b64.busy), 64'd0);
        check("rst_done", 64'(b64.done), 64'd0);
        check("rst_result", b64.result, 64'd0);
        check("rst_nzcv", 64'(flags_of(1'b0)), 64'd0);
        check("rst_result8", 64'(b8.result), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op(1'b0, 64'd5, 64'd7, 1'b0, "add_5_7");
        run_op(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, "add_ovf");
        run_op(1'b0, 64'd3, 64'd3, 1'b1, "sub_eq");
        run_op(1'b1, 64'h00, 64'h01, 1'b1, "w8_sub_borrow");

        // Start during RUN must neither disturb nor queue
        drive(1'b0, 1'b1, 64'd10, 64'd20, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 64'd10, 64'd20, 1'b0);
        first_done = 0; done_cnt = 0;
        for (int cyc = 1; cyc < 170; cyc++) begin
            if (cyc == 10) drive(1'b0, 1'b1, 64'd999, 64'd1, 1'b1);
            if (cyc == 11) drive(1'b0, 1'b0, 64'd999, 64'd1, 1'b1);
            @(posedge clk); #1;
            if (b64.done) begin
                done_cnt++;
                if (first_done == 0) begin
                    first_done = cyc;
                    check("ign_result", b64.result, 64'd30);
                end
            end
        end
        check("ign_latency", 64'(first_done), 64'd65);
        check("ign_done_count", 64'(done_cnt), 64'd1);

        // Start held high: back-to-back operations
        drive(1'b0, 1'b1, 64'd1, 64'd2, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 64'd4, 64'd4, 1'b0);
        first_done = 0; second_done = 0; hold_ok = 1'b1;
        for (int cyc = 1; cyc < 300; cyc++) begin
            @(posedge clk); #1;
            if (first_done != 0 && cyc == first_done + 64) drive(1'b0, 1'b0, 64'd4, 64'd4, 1'b0);
            if (first_done != 0 && second_done == 0 && cyc < first_done + 64 && b64.result !== 64'd3)
                hold_ok = 1'b0;
            if (b64.done) begin
                if (first_done == 0) begin
                    first_done = cyc;
                    check("b2b_result1", b64.result, 64'd3);
                end else begin
                    second_done = cyc;
                    check("b2b_result2", b64.result, 64'd8);
                    break;
                end
            end
        end
        check("b2b_latency1", 64'(first_done), 64'd65);
        check("b2b_spacing", 64'(second_done - first_done), 64'd65);
        check("b2b_hold", 64'(hold_ok), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        check("b2b_no_third", 64'(b64.busy), 64'd0);

        for (int i = 0; i < 24; i++) begin
            bit w8 = (i % 3 == 2);
            int w  = w8 ? 8 : 64;
            ra = rnd_operand(w);
            rb = rnd_operand(w);
            rs = 1'($urandom_range(0, 1));
            run_op(w8, ra, rb, rs, $sformatf("rnd%0d", i));
        end

        // Reset mid-RUN aborts: no done, everything back to zero
        drive(1'b0, 1'b1, 64'hDEAD_BEEF_0000_1234, 64'h1111, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
        cyc0 = 0; done_cnt = 0; busy_cnt = 0;
        for (int cyc = 1; cyc <= 21; cyc++) begin
            if (cyc == 10) drive(1'b0, 1'b1, 64'd77, 64'd1, 1'b0);
            if (cyc == 11) drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
            if (cyc == 20) reset = 1'b1;
            @(posedge clk); #1;
            if (b64.done) done_cnt++;
            cyc0 = cyc;
        end
        reset = 1'b0;
        check("rr_cycles", 64'(cyc0), 64'd21);
        check("rr_busy", 64'(b64.busy), 64'd0);
        check("rr_result", b64.result, 64'd0);
        check("rr_nzcv", 64'(flags_of(1'b0)), 64'd0);
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(posedge clk); #1;
            if (b64.done) done_cnt++;
            if (b64.busy) busy_cnt++;
        end
        check("rr_no_done", 64'(done_cnt), 64'd0);
        check("rr_no_busy", 64'(busy_cnt), 64'd0);

        run_op(1'b0, 64'd0, 64'd0, 1'b0, "post_rst_zero");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
